instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front-end fetch stage of the SigmaCore pipeline.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with a response channel.
- Holds the fetched word in the IF/ID register: instruction_out drives the decoder and the sign extender's instruction input directly.
- Supports decode back-pressure (stall), branch/jump redirect with in-flight response squashing, and a one-entry skid buffer.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address after reset.
- NOP_INSTR, 32'h0000_0013: value of instruction_out when invalid or flushed (addi x0,x0,0).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous reset, active-high.
- imem_req_valid_out  output  1  fetch request valid.
- imem_req_addr_out  output  32  word-aligned fetch address.
- imem_req_ready_in  input  1  memory accepts the request this cycle.
- imem_rsp_valid_in  input  1  response data valid; memory cannot be back-pressured.
- imem_rsp_data_in  input  32  fetched instruction word.
- stall_in  input  1  decode cannot consume instruction_out this cycle.
- redirect_valid_in  input  1  branch/jump taken; flush and refetch.
- redirect_pc_in  input  32  redirect target; bits [1:0] are ignored and treated as 00.
- instruction_out  output  32  IF/ID instruction.
- pc_out  output  32  PC of instruction_out.
- pc_plus4_out  output  32  pc_out+4, registered.
- instr_valid_out  output  1  IF/ID contents valid.

Behaviour:
- Reset (rst_in=1 at an edge):
  - fetch_pc=RESET_PC, state=FETCH, skid empty.
  - instruction_out=NOP_INSTR, pc_out=RESET_PC, pc_plus4_out=RESET_PC+4, instr_valid_out=0.
  - Reset mid-transaction abandons any outstanding response. The memory model is reset with the core.
- Request outputs:
  - imem_req_valid_out = (state==FETCH) && !rst_in.
  - imem_req_addr_out = fetch_pc.
  - At most one outstanding request. Throughput is 1 instruction per 2 cycles with a zero-wait memory.
- States FETCH, WAIT, HOLD, DISCARD. Transitions without a redirect:
  - FETCH: on req_valid && req_ready, latch req_pc=fetch_pc and go to WAIT.
  - WAIT, rsp_valid, output free (instr_valid_out==0 or stall_in==0): load instruction_out=data, pc_out=req_pc, pc_plus4_out=req_pc+4, valid=1; fetch_pc=req_pc+4; go to FETCH.
  - WAIT, rsp_valid, output blocked: capture data and req_pc into skid; fetch_pc=req_pc+4; go to HOLD.
  - HOLD: when stall_in==0, move skid to IF/ID (valid=1), clear skid, go to FETCH.
- Consumption:
  - If instr_valid_out && !stall_in and no new word is loaded that cycle, instr_valid_out→0 and instruction_out→NOP_INSTR.
  - While stalled, all IF/ID outputs hold.
- Redirect has the highest priority over stall and response:
  - At the edge: fetch_pc={redirect_pc_in[31:2],2'b00}, instr_valid_out=0, instruction_out=NOP_INSTR, skid cleared.
  - From FETCH with the request accepted the same cycle: go to DISCARD.
  - From FETCH not accepted: stay in FETCH. The address changes next cycle; this is the only permitted change of a pending unaccepted request.
  - From WAIT without rsp: go to DISCARD.
  - From WAIT with rsp the same cycle: drop the response, go to FETCH.
  - From HOLD: go to FETCH.
  - From DISCARD: update fetch_pc and stay in DISCARD, unless rsp arrives the same cycle, then go to FETCH.
- DISCARD: on rsp_valid, drop the data (IF/ID untouched) and go to FETCH.
- Arithmetic:
  - All PC adds are 32-bit modulo; 0xFFFF_FFFC+4 = 0x0000_0000.
  - fetch_pc[1:0] is always 00.
- Protocol errors:
  - rsp_valid in FETCH or HOLD is ignored.
  - An assertion fires in simulation.

Test Plan:
- Reset, then ready=1 and 1-cycle response latency returning 0x00500093 then 0xFFB00093 → requests at 0x0, 0x4; IF/ID shows (0x0, 0x00500093, valid), then (0x4, 0xFFB00093); pc_plus4_out 0x4, then 0x8.
- stall_in high while the response 0xFE002823 for 0x8 arrives → IF/ID holds the previous word, state HOLD, no new request. Release the stall → IF/ID = (0x8, 0xFE002823) the next cycle, and the request for 0xC issues.
- Redirect to 0x0000_0103 while in WAIT; stale response arrives 2 cycles later → stale data never reaches the outputs, instr_valid_out=0, next request addr=0x0000_0100.
- Redirect in the same cycle as rsp_valid, with stall_in=1 → response dropped, IF/ID flushed to NOP_INSTR/valid=0, request to the target issued the next cycle.
- Redirect to 0xFFFF_FFFC, returning 0x3E80006F → IF/ID pc_out=0xFFFF_FFFC, pc_plus4_out=0x0; next fetch addr=0x0.
- rst_in asserted during WAIT with imem_req_ready_in held low after reset → outputs return to reset values; imem_req_valid_out=1 at addr RESET_PC and held stable until accepted.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end.
// Owns the fetch PC and keeps at most one word request outstanding to
// instruction memory. The returned word goes into the IF/ID register, or into a
// one-entry skid buffer while decode is stalled. A redirect flushes IF/ID and
// squashes any response that is still in flight.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_in,
   input  logic        rst_in,
   output logic        imem_req_valid_out,
   output logic [31:0] imem_req_addr_out,
   input  logic        imem_req_ready_in,
   input  logic        imem_rsp_valid_in,
   input  logic [31:0] imem_rsp_data_in,
   input  logic        stall_in,
   input  logic        redirect_valid_in,
   input  logic [31:0] redirect_pc_in,
   output logic [31:0] instruction_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4_out,
   output logic        instr_valid_out
);

   // FETCH: request pending; WAIT: response outstanding;
   // HOLD: skid buffer full, waiting for decode; DISCARD: squash the in-flight response
   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_WAIT    = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } state_t;

   // Reset PC is forced onto a word boundary, like every other fetch address
   localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

   // Sequential PC step; wraps modulo 2^32
   function automatic logic [31:0] pc_add4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

   // Clears the byte-offset bits of a target address
   function automatic logic [31:0] word_align(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   state_t      state;
   state_t      state_n;
   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic [31:0] skid_data;
   logic [31:0] skid_pc;

   logic        req_fire;
   logic        out_free;
   logic        rsp_to_ifid;
   logic        rsp_to_skid;
   logic        skid_to_ifid;
   logic        rsp_taken;

   // The low two bits of the redirect target carry no information
   logic        unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc_in[1:0];

   // Request channel: the address only ever comes from fetch_pc
   always_comb begin
      imem_req_valid_out = (state == ST_FETCH) && !rst_in;
      imem_req_addr_out  = fetch_pc;
   end

   // Decode of the handshake and buffer-move conditions for this cycle
   always_comb begin
      req_fire     = imem_req_valid_out && imem_req_ready_in;
      out_free     = !instr_valid_out || !stall_in;
      rsp_taken    = !redirect_valid_in && (state == ST_WAIT) && imem_rsp_valid_in;
      rsp_to_ifid  = rsp_taken && out_free;
      rsp_to_skid  = rsp_taken && !out_free;
      skid_to_ifid = !redirect_valid_in && (state == ST_HOLD) && !stall_in;
   end

   // State register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= ST_FETCH;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic; a redirect overrides stall and response handling
   always_comb begin
      state_n = state;
      if (redirect_valid_in) begin
         unique case (state)
            ST_FETCH:   state_n = req_fire ? ST_DISCARD : ST_FETCH;
            ST_WAIT:    state_n = imem_rsp_valid_in ? ST_FETCH : ST_DISCARD;
            ST_HOLD:    state_n = ST_FETCH;
            ST_DISCARD: state_n = imem_rsp_valid_in ? ST_FETCH : ST_DISCARD;
            default:    state_n = ST_FETCH;
         endcase
      end else begin
         unique case (state)
            ST_FETCH: begin
               if (req_fire) begin
                  state_n = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid_in) begin
                  state_n = out_free ? ST_FETCH : ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!stall_in) begin
                  state_n = ST_FETCH;
               end
            end
            ST_DISCARD: begin
               if (imem_rsp_valid_in) begin
                  state_n = ST_FETCH;
               end
            end
            default: state_n = ST_FETCH;
         endcase
      end
   end

   // Fetch PC: redirect target, else the word after the one just returned
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fetch_pc <= RESET_PC_A;
      end else if (redirect_valid_in) begin
         fetch_pc <= word_align(redirect_pc_in);
      end else if (rsp_taken) begin
         fetch_pc <= pc_add4(req_pc);
      end
   end

   // PC of the outstanding request, captured at the handshake
   always_ff @(posedge clk_in) begin
      if (req_fire) begin
         req_pc <= fetch_pc;
      end
   end

   // Skid buffer data; occupancy is tracked by the HOLD state
   always_ff @(posedge clk_in) begin
      if (rsp_to_skid) begin
         skid_data <= imem_rsp_data_in;
         skid_pc   <= req_pc;
      end
   end

   // IF/ID register: flush on redirect, load from memory or skid, drop on consume
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         instruction_out <= NOP_INSTR;
         pc_out          <= RESET_PC_A;
         pc_plus4_out    <= pc_add4(RESET_PC_A);
         instr_valid_out <= 1'b0;
      end else if (redirect_valid_in) begin
         instruction_out <= NOP_INSTR;
         instr_valid_out <= 1'b0;
      end else if (rsp_to_ifid) begin
         instruction_out <= imem_rsp_data_in;
         pc_out          <= req_pc;
         pc_plus4_out    <= pc_add4(req_pc);
         instr_valid_out <= 1'b1;
      end else if (skid_to_ifid) begin
         instruction_out <= skid_data;
         pc_out          <= skid_pc;
         pc_plus4_out    <= pc_add4(skid_pc);
         instr_valid_out <= 1'b1;
      end else if (instr_valid_out && !stall_in) begin
         instruction_out <= NOP_INSTR;
         instr_valid_out <= 1'b0;
      end
   end

   // A response with no request outstanding means the memory broke the protocol
   rsp_without_request: assert property (
      @(posedge clk_in) disable iff (rst_in)
         !(imem_rsp_valid_in && ((state == ST_FETCH) || (state == ST_HOLD)))
   );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: the memory side is driven by hand,
// one cycle at a time, and every output is checked against hand-derived values.
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk_in;
   logic        rst_in;
   logic        imem_req_valid_out;
   logic [31:0] imem_req_addr_out;
   logic        imem_req_ready_in;
   logic        imem_rsp_valid_in;
   logic [31:0] imem_rsp_data_in;
   logic        stall_in;
   logic        redirect_valid_in;
   logic [31:0] redirect_pc_in;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4_out;
   logic        instr_valid_out;

   int total;
   int bad;

   instr_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .imem_req_valid_out (imem_req_valid_out),
      .imem_req_addr_out  (imem_req_addr_out),
      .imem_req_ready_in  (imem_req_ready_in),
      .imem_rsp_valid_in  (imem_rsp_valid_in),
      .imem_rsp_data_in   (imem_rsp_data_in),
      .stall_in           (stall_in),
      .redirect_valid_in  (redirect_valid_in),
      .redirect_pc_in     (redirect_pc_in),
      .instruction_out    (instruction_out),
      .pc_out             (pc_out),
      .pc_plus4_out       (pc_plus4_out),
      .instr_valid_out    (instr_valid_out)
   );

   // 100 MHz clock
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle away from it
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Compare the whole IF/ID register
   task automatic check_ifid(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc, input logic [31:0] pc4,
                             input logic vld);
      check({tag, ".instr"}, instruction_out, instr);
      check({tag, ".pc"}, pc_out, pc);
      check({tag, ".pc4"}, pc_plus4_out, pc4);
      check({tag, ".valid"}, {31'd0, instr_valid_out}, {31'd0, vld});
   endtask

   task automatic check_req(input string tag, input logic vld, input logic [31:0] addr);
      check({tag, ".req_valid"}, {31'd0, imem_req_valid_out}, {31'd0, vld});
      if (vld) check({tag, ".req_addr"}, imem_req_addr_out, addr);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_in = 1'b1;
      imem_req_ready_in = 1'b0;
      imem_rsp_valid_in = 1'b0;
      imem_rsp_data_in = 32'h0;
      stall_in = 1'b0;
      redirect_valid_in = 1'b0;
      redirect_pc_in = 32'h0;

      // Reset state
      step();
      step();
      check_ifid("reset", NOP, 32'h0, 32'h4, 1'b0);
      check_req("reset", 1'b0, 32'h0);
      rst_in = 1'b0;
      #1;
      check_req("post_reset", 1'b1, 32'h0);

      // Two back-to-back fetches with a one-cycle memory
      imem_req_ready_in = 1'b1;
      step();
      check_req("t1_wait0", 1'b0, 32'h0);
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in = 32'h0050_0093;
      step();
      imem_rsp_valid_in = 1'b0;
      check_ifid("t1_w0", 32'h0050_0093, 32'h0, 32'h4, 1'b1);
      check_req("t1_req1", 1'b1, 32'h4);
      step();
      check_ifid("t1_consumed", NOP, 32'h0, 32'h4, 1'b0);
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in = 32'hFFB0_0093;
      step();
      imem_rsp_valid_in = 1'b0;
      check_ifid("t1_w1", 32'hFFB0_0093, 32'h4, 32'h8, 1'b1);
      check_req("t1_req2", 1'b1, 32'h8);

      // Response arrives under stall: goes to the skid buffer
      stall_in = 1'b1;
      step();
      check_ifid("t2_held", 32'hFFB0_0093, 32'h4, 32'h8, 1'b1);
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in = 32'hFE00_2823;
      step();
      imem_rsp_valid_in = 1'b0;
      check_ifid("t2_hold", 32'hFFB0_0093, 32'h4, 32'h8, 1'b1);
      check_req("t2_hold", 1'b0, 32'h0);
      step();
      check_ifid("t2_hold2", 32'hFFB0_0093, 32'h4, 32'h8, 1'b1);
      check_req("t2_hold2", 1'b0, 32'h0);
      stall_in = 1'b0;
      step();
      check_ifid("t2_skid", 32'hFE00_2823, 32'h8, 32'hC, 1'b1);
      check_req("t2_req", 1'b1, 32'hC);

      // Redirect while waiting; stale response two cycles later is squashed
      step();
      check_ifid("t3_consumed", NOP, 32'h8, 32'hC, 1'b0);
      redirect_valid_in = 1'b1;
      redirect_pc_in = 32'h0000_0103;
      step();
      redirect_valid_in = 1'b0;
      check_req("t3_discard", 1'b0, 32'h0);
      check("t3_discard.valid", {31'd0, instr_valid_out}, 32'd0);
      step();
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in = 32'hDEAD_BEEF;
      step();
      imem_rsp_valid_in = 1'b0;
      check("t3_stale.instr", instruction_out, NOP);
      check("t3_stale.valid", {31'd0, instr_valid_out}, 32'd0);
      check_req("t3_req", 1'b1, 32'h0000_0100);

      // Redirect coincident with a response while decode is stalled
      step();
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in = 32'h1111_1111;
      step();
      imem_rsp_valid_in = 1'b0;
      check_ifid("t4_w", 32'h1111_1111, 32'h100, 32'h104, 1'b1);
      stall_in = 1'b1;
      step();
      check_ifid("t4_held", 32'h1111_1111, 32'h100, 32'h104, 1'b1);
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in = 32'h2222_2222;
      redirect_valid_in = 1'b1;
      redirect_pc_in = 32'h0000_0200;
      step();
      imem_rsp_valid_in = 1'b0;
      redirect_valid_in = 1'b0;
      stall_in = 1'b0;
      check("t4_flush.instr", instruction_out, NOP);
      check("t4_flush.valid", {31'd0, instr_valid_out}, 32'd0);
      check_req("t4_req", 1'b1, 32'h0000_0200);

      // Redirect of a pending unaccepted request to the top word; PC wraps
      imem_req_ready_in = 1'b0;
      redirect_valid_in = 1'b1;
      redirect_pc_in = 32'hFFFF_FFFF;
      step();
      redirect_valid_in = 1'b0;
      check_req("t5_retarget", 1'b1, 32'hFFFF_FFFC);
      imem_req_ready_in = 1'b1;
      step();
      imem_rsp_valid_in = 1'b1;
      imem_rsp_data_in = 32'h3E80_006F;
      step();
      imem_rsp_valid_in = 1'b0;
      check_ifid("t5_wrap", 32'h3E80_006F, 32'hFFFF_FFFC, 32'h0, 1'b1);
      check_req("t5_req", 1'b1, 32'h0);

      // Reset while a response is outstanding, memory not ready afterwards
      step();
      imem_req_ready_in = 1'b0;
      rst_in = 1'b1;
      step();
      check_ifid("t6_reset", NOP, 32'h0, 32'h4, 1'b0);
      check_req("t6_in_reset", 1'b0, 32'h0);
      rst_in = 1'b0;
      #1;
      check_req("t6_req0", 1'b1, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_req("t6_req_stable", 1'b1, 32'h0);
         check("t6_valid_low", {31'd0, instr_valid_out}, 32'd0);
      end
      imem_req_ready_in = 1'b1;
      step();
      check_req("t6_accepted", 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
